lc3_sp_bank: RTL and testbench

- Parametrised stack-pointer unit for the LC-3 datapath.
- Holds NUM_CTX saved stack pointers, one per privilege/interrupt context (context 0 = user, context NUM_CTX-1 = supervisor).
- Performs bounds-checked push/pop arithmetic on SR1OUT and a sequenced two-cycle context switch (save current SP, load target SP).
- Drives its registered result onto the shared main bus through a tri-state gate, as the control FSM directs.

---
 rtl/lc3_sp_bank.sv | 137 +++++++++++++
 tb/tb_lc3_sp_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_sp_bank.sv
// LC-3 stack-pointer unit: per-context saved SP bank, bounds-checked push/pop,
// two-cycle context switch and a tri-state drive of the result onto the main bus.
module lc3_sp_bank #(
   parameter int               WIDTH    = 16,
   parameter int               NUM_CTX  = 2,
   parameter int               CTX_W    = 1,
   parameter int               STEP     = 1,
   parameter logic [WIDTH-1:0] SSP_INIT = 16'h3000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [CTX_W-1:0] ctx_sel,
   input  logic [WIDTH-1:0] sr1_out,
   input  logic [WIDTH-1:0] stack_lo,
   input  logic [WIDTH-1:0] stack_hi,
   input  logic             gate_sp,
   output logic             op_ready,
   output logic [WIDTH-1:0] sp_result,
   output logic             result_valid,
   output logic             stack_fault,
   output logic [CTX_W-1:0] cur_ctx,
   output logic [WIDTH-1:0] main_bus
);

   localparam int               BANK_N    = 2 ** CTX_W;
   localparam logic [WIDTH:0]   STEP_X    = (WIDTH + 1)'(STEP);
   localparam logic [CTX_W:0]   NUM_CTX_X = (CTX_W + 1)'(NUM_CTX);

   localparam logic [2:0] OP_POP     = 3'b001;
   localparam logic [2:0] OP_PUSH    = 3'b010;
   localparam logic [2:0] OP_SAVE    = 3'b011;
   localparam logic [2:0] OP_RESTORE = 3'b100;
   localparam logic [2:0] OP_SWITCH  = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      SW_SAVE,
      SW_LOAD
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] bank [BANK_N];
   logic [WIDTH-1:0] cap_sr1;
   logic [CTX_W-1:0] cap_ctx;

   logic [WIDTH:0]   pop_sum;
   logic [WIDTH:0]   push_floor;
   logic             pop_fault;
   logic             push_fault;
   logic             ctx_ok;

   // Bounds are checked one bit wider so wrap past either end shows up as a fault.
   assign pop_sum    = {1'b0, sr1_out} + STEP_X;
   assign pop_fault  = pop_sum > {1'b0, stack_hi};
   assign push_floor = {1'b0, stack_lo} + STEP_X;
   assign push_fault = {1'b0, sr1_out} < push_floor;
   assign ctx_ok     = {1'b0, ctx_sel} < NUM_CTX_X;

   assign main_bus = gate_sp ? sp_result : {WIDTH{1'bz}};

   // Bank entries beyond NUM_CTX are never written and stay at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BANK_N; i++) begin
            bank[i] <= (i == NUM_CTX - 1) ? SSP_INIT : '0;
         end
         state        <= IDLE;
         op_ready     <= 1'b1;
         sp_result    <= '0;
         result_valid <= 1'b0;
         stack_fault  <= 1'b0;
         cur_ctx      <= '0;
         cap_sr1      <= '0;
         cap_ctx      <= '0;
      end else begin
         result_valid <= 1'b0;
         stack_fault  <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid) begin
                  case (op)
                     OP_POP: begin
                        result_valid <= 1'b1;
                        stack_fault  <= pop_fault;
                        sp_result    <= pop_fault ? sr1_out : pop_sum[WIDTH-1:0];
                     end
                     OP_PUSH: begin
                        result_valid <= 1'b1;
                        stack_fault  <= push_fault;
                        sp_result    <= push_fault ? sr1_out : sr1_out - STEP_X[WIDTH-1:0];
                     end
                     OP_SAVE, OP_RESTORE, OP_SWITCH: begin
                        if (!ctx_ok) begin
                           result_valid <= 1'b1;
                           stack_fault  <= 1'b1;
                           sp_result    <= sr1_out;
                        end else if (op == OP_SAVE) begin
                           bank[ctx_sel] <= sr1_out;
                           sp_result     <= sr1_out;
                           result_valid  <= 1'b1;
                        end else if (op == OP_RESTORE) begin
                           sp_result    <= bank[ctx_sel];
                           result_valid <= 1'b1;
                        end else begin
                           cap_sr1  <= sr1_out;
                           cap_ctx  <= ctx_sel;
                           op_ready <= 1'b0;
                           state    <= SW_SAVE;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            SW_SAVE: begin
               bank[cur_ctx] <= cap_sr1;
               state         <= SW_LOAD;
            end
            // Load happens a cycle after the save so a same-context switch returns the saved SP.
            SW_LOAD: begin
               sp_result    <= bank[cap_ctx];
               cur_ctx      <= cap_ctx;
               result_valid <= 1'b1;
               op_ready     <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               op_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_sp_bank.sv
// Self-checking bench for lc3_sp_bank: directed scenarios followed by randomized
// commands compared against an integer-level model of the SP bank.
module tb_lc3_sp_bank;

   localparam int WIDTH   = 16;
   localparam int NUM_CTX = 2;
   localparam int CTX_W   = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             op_valid;
   logic [2:0]       op;
   logic [CTX_W-1:0] ctx_sel;
   logic [WIDTH-1:0] sr1_out;
   logic [WIDTH-1:0] stack_lo;
   logic [WIDTH-1:0] stack_hi;
   logic             gate_sp;
   logic             op_ready;
   logic [WIDTH-1:0] sp_result;
   logic             result_valid;
   logic             stack_fault;
   logic [CTX_W-1:0] cur_ctx;
   wire  [WIDTH-1:0] main_bus;

   int checks = 0;
   int errors = 0;
   int bank_m [NUM_CTX];
   int cur_m;
   int sp_m;

   lc3_sp_bank #(
      .WIDTH(WIDTH),
      .NUM_CTX(NUM_CTX),
      .CTX_W(CTX_W),
      .STEP(1),
      .SSP_INIT(16'h3000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .op_valid(op_valid),
      .op(op),
      .ctx_sel(ctx_sel),
      .sr1_out(sr1_out),
      .stack_lo(stack_lo),
      .stack_hi(stack_hi),
      .gate_sp(gate_sp),
      .op_ready(op_ready),
      .sp_result(sp_result),
      .result_valid(result_valid),
      .stack_fault(stack_fault),
      .cur_ctx(cur_ctx),
      .main_bus(main_bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < NUM_CTX; i++) bank_m[i] = 0;
      bank_m[NUM_CTX-1] = 'h3000;
      cur_m = 0;
      sp_m  = 0;
   endtask

   // Called at a falling edge; returns at the falling edge where the result is visible,
   // so consecutive calls issue commands back to back.
   task automatic applyStimulus(input logic [2:0] o, input int c, input int s);
      int lo;
      int hi;
      bit flt;
      bit rv;
      bit sw;
      lo  = int'(stack_lo);
      hi  = int'(stack_hi);
      flt = 0;
      rv  = 1;
      sw  = 0;
      case (o)
         3'd1: if (s + 1 > hi) begin flt = 1; sp_m = s; end else sp_m = s + 1;
         3'd2: if (s < lo + 1) begin flt = 1; sp_m = s; end else sp_m = s - 1;
         3'd3, 3'd4, 3'd5: begin
            if (c >= NUM_CTX) begin
               flt  = 1;
               sp_m = s;
            end else if (o == 3'd3) begin
               bank_m[c] = s;
               sp_m      = s;
            end else if (o == 3'd4) begin
               sp_m = bank_m[c];
            end else begin
               bank_m[cur_m] = s;
               sp_m          = bank_m[c];
               cur_m         = c;
               sw            = 1;
            end
         end
         default: rv = 0;
      endcase

      op_valid = 1'b1;
      op       = o;
      ctx_sel  = CTX_W'(c);
      sr1_out  = WIDTH'(s);
      @(negedge clk);
      if (sw) begin
         op      = 3'b010;
         sr1_out = WIDTH'($urandom);
         checkOutput("switch busy1 op_ready", 32'(op_ready), 32'd0);
         checkOutput("switch busy1 result_valid", 32'(result_valid), 32'd0);
         @(negedge clk);
         checkOutput("switch busy2 op_ready", 32'(op_ready), 32'd0);
         checkOutput("switch busy2 result_valid", 32'(result_valid), 32'd0);
         op_valid = 1'b0;
         @(negedge clk);
      end
      op_valid = 1'b0;
      checkOutput($sformatf("op%0d result_valid", o), 32'(result_valid), 32'(rv));
      checkOutput($sformatf("op%0d stack_fault", o), 32'(stack_fault), 32'(flt));
      checkOutput($sformatf("op%0d sp_result", o), 32'(sp_result), sp_m);
      checkOutput($sformatf("op%0d cur_ctx", o), 32'(cur_ctx), cur_m);
      checkOutput($sformatf("op%0d op_ready", o), 32'(op_ready), 32'd1);
   endtask

   initial begin
      int lo_r;
      int hi_r;
      int s;
      int k;
      rst      = 1'b1;
      op_valid = 1'b0;
      op       = 3'b000;
      ctx_sel  = '0;
      sr1_out  = '0;
      stack_lo = 16'h2F00;
      stack_hi = 16'h3000;
      gate_sp  = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset cur_ctx", 32'(cur_ctx), 32'd0);
      checkOutput("reset op_ready", 32'(op_ready), 32'd1);
      checkOutput("reset result_valid", 32'(result_valid), 32'd0);
      checkOutput("reset sp_result", 32'(sp_result), 32'd0);
      rst = 1'b0;
      resetModel();
      @(negedge clk);

      applyStimulus(3'd4, 1, 0);
      applyStimulus(3'd2, 0, 'h3000);
      applyStimulus(3'd1, 0, 'h3000);
      stack_lo = 16'h0000;
      applyStimulus(3'd2, 0, 'h0000);
      stack_hi = 16'hFFFF;
      applyStimulus(3'd1, 0, 'hFFFF);
      applyStimulus(3'd0, 0, 'h5555);
      applyStimulus(3'd7, 1, 'h5555);
      applyStimulus(3'd5, 1, 'hFDFF);
      applyStimulus(3'd4, 0, 'h1111);
      applyStimulus(3'd5, 2, 'hABCD);
      applyStimulus(3'd4, 1, 'h2222);
      applyStimulus(3'd5, 1, 'h4321);

      // Reset lands while the switch is in its save cycle.
      op_valid = 1'b1;
      op       = 3'b101;
      ctx_sel  = '0;
      sr1_out  = 16'h4444;
      @(negedge clk);
      op_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("midswitch reset cur_ctx", 32'(cur_ctx), 32'd0);
      checkOutput("midswitch reset sp_result", 32'(sp_result), 32'd0);
      checkOutput("midswitch reset result_valid", 32'(result_valid), 32'd0);
      checkOutput("midswitch reset op_ready", 32'(op_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      @(negedge clk);
      applyStimulus(3'd4, 0, 'h0F0F);
      applyStimulus(3'd4, 1, 'h0F0F);

      applyStimulus(3'd3, 0, 'h1234);
      for (int i = 0; i < 4; i++) begin
         gate_sp = i[0];
         #1;
         checkOutput("main_bus gating", 32'(main_bus === 16'h1234), 32'(gate_sp));
      end
      gate_sp = 1'b0;
      @(negedge clk);

      repeat (300) begin
         lo_r = $urandom_range(0, 'hFFFF);
         hi_r = $urandom_range(lo_r, 'hFFFF);
         stack_lo = WIDTH'(lo_r);
         stack_hi = WIDTH'(hi_r);
         k = $urandom_range(0, 5);
         case (k)
            0: s = $urandom_range(0, 'hFFFF);
            1: s = lo_r;
            2: s = hi_r;
            3: s = (lo_r + 1) % 'h10000;
            4: s = (hi_r + 1) % 'h10000;
            default: s = ($urandom_range(0, 1) == 1) ? 'hFFFF : 0;
         endcase
         applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 3), s);
         if ($urandom_range(0, 3) == 0) begin
            gate_sp = 1'b1;
            #1;
            checkOutput("main_bus driven", 32'(main_bus), sp_m);
            gate_sp = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
